// File: rtl/sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sequencer_pkg: state encoding, default phase map and config checks
// Revision: 1.0
// ----------------------------------------------------------------------------
package sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

  localparam int PERIOD        = 6;
  localparam int IMEM_PHASE    = 1;
  localparam int DMEM_PHASE    = 3;
  localparam int REGFILE_PHASE = 4;

  function automatic bit cfg_ok(int period, int imem, int dmem, int regf, int cnt_w);
    return (period >= 3) && (period <= 15) &&
           (imem >= 0) && (imem < period) &&
           (dmem >= 0) && (dmem < period) &&
           (regf >= 0) && (regf < period) &&
           ((1 << cnt_w) >= period);
  endfunction

  // `last` is high while the phase counter sits on PERIOD-1.
  function automatic seq_state_t next_state(seq_state_t cur, logic run, logic step,
                                            logic last);
    seq_state_t nxt;
    nxt = cur;
    case (cur)
      IDLE:    if (run) nxt = RUN; else if (step) nxt = STEP;
      // Dropping run on the final phase ends the cycle right there, rather
      // than draining a whole extra processor cycle.
      RUN:     if (!run) nxt = last ? IDLE : DRAIN;
      STEP:    if (last) nxt = IDLE;
      DRAIN:   if (run) nxt = RUN; else if (last) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_sequencer_mod_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mod_counter: modulo-MODULUS counter with enable, sync clear and terminal count
// Revision: 1.0
// ----------------------------------------------------------------------------
module mod_counter #(
  parameter int MODULUS = 6,
  parameter int WIDTH   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next,
  output logic             tc
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  assign tc = (count == LAST);

  // The next value is exported so the owner can register decodes of it.
  always_comb begin
    count_next = count;
    if (clr)
      count_next = '0;
    else if (en)
      count_next = tc ? '0 : count + WIDTH'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      count <= '0;
    else
      count <= count_next;
  end

endmodule
`default_nettype wire

// File: rtl/phase_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// phase_sequencer: splits the master clock into processor cycles with phase strobes
// Revision: 1.0
// ----------------------------------------------------------------------------
module phase_sequencer
  import sequencer_pkg::*;
#(
  parameter int PERIOD        = sequencer_pkg::PERIOD,
  parameter int IMEM_PHASE    = sequencer_pkg::IMEM_PHASE,
  parameter int DMEM_PHASE    = sequencer_pkg::DMEM_PHASE,
  parameter int REGFILE_PHASE = sequencer_pkg::REGFILE_PHASE,
  parameter int CNT_W         = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  output logic [CNT_W-1:0] phase,
  output logic             imem_en,
  output logic             dmem_en,
  output logic             regfile_en,
  output logic             processor_en,
  output logic             busy,
  output logic             step_done,
  output logic [31:0]      cycle_count
);

  if (!cfg_ok(PERIOD, IMEM_PHASE, DMEM_PHASE, REGFILE_PHASE, CNT_W)) begin : g_bad_cfg
    $error("phase_sequencer: illegal PERIOD / phase / CNT_W combination");
  end

  localparam logic [CNT_W-1:0] IMEM_P = CNT_W'(IMEM_PHASE);
  localparam logic [CNT_W-1:0] DMEM_P = CNT_W'(DMEM_PHASE);
  localparam logic [CNT_W-1:0] REGF_P = CNT_W'(REGFILE_PHASE);
  localparam logic [CNT_W-1:0] LAST_P = CNT_W'(PERIOD - 1);

  seq_state_t       state;
  seq_state_t       state_next;
  logic [CNT_W-1:0] phase_next;
  logic             last;
  logic             count_en;
  logic             count_clr;
  logic             active_next;

  assign count_en  = (state != IDLE);
  assign count_clr = (state == IDLE);

  mod_counter #(
    .MODULUS (PERIOD),
    .WIDTH   (CNT_W)
  ) u_phase (
    .clock      (clock),
    .reset      (reset),
    .en         (count_en),
    .clr        (count_clr),
    .count      (phase),
    .count_next (phase_next),
    .tc         (last)
  );

  assign state_next  = next_state(state, run, step, last);
  assign active_next = (state_next != IDLE);

  // Outputs decode the upcoming state/phase so each one is a plain flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      imem_en      <= 1'b0;
      dmem_en      <= 1'b0;
      regfile_en   <= 1'b0;
      processor_en <= 1'b0;
      busy         <= 1'b0;
      step_done    <= 1'b0;
      cycle_count  <= '0;
    end else begin
      state        <= state_next;
      imem_en      <= active_next && (phase_next == IMEM_P);
      dmem_en      <= active_next && (phase_next == DMEM_P);
      regfile_en   <= active_next && (phase_next == REGF_P);
      processor_en <= active_next && (phase_next == LAST_P);
      busy         <= active_next;
      step_done    <= (state_next == STEP) && (phase_next == LAST_P);
      cycle_count  <= cycle_count + 32'(processor_en);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_phase_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_phase_sequencer: vector table plus scoreboard for phase_sequencer defaults
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_phase_sequencer;

  typedef struct packed {
    logic [3:0]  ph;
    logic [3:0]  str;   // {imem, dmem, regfile, processor}
    logic        busy;
    logic        sd;
    logic [31:0] cnt;
  } outs_t;

  typedef struct {
    bit    run;
    bit    step;
    outs_t exp;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run   = 1'b0;
  logic        step  = 1'b0;
  logic [3:0]  phase;
  logic        imem_en, dmem_en, regfile_en, processor_en, busy, step_done;
  logic [31:0] cycle_count;

  int    checks = 0;
  int    errors = 0;
  vec_t  vecs[$];
  outs_t sb[$];
  int    split;

  phase_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .run          (run),
    .step         (step),
    .phase        (phase),
    .imem_en      (imem_en),
    .dmem_en      (dmem_en),
    .regfile_en   (regfile_en),
    .processor_en (processor_en),
    .busy         (busy),
    .step_done    (step_done),
    .cycle_count  (cycle_count)
  );

  always #5 clock = ~clock;

  // Strobe positions for the default map: imem 1, dmem 3, regfile 4, commit 5.
  function automatic outs_t mk(int ph, bit b, bit sd, int cnt);
    outs_t o;
    o.ph   = 4'(ph);
    o.str  = {b && ph == 1, b && ph == 3, b && ph == 4, b && ph == 5};
    o.busy = b;
    o.sd   = sd;
    o.cnt  = 32'(cnt);
    return o;
  endfunction

  task automatic add(bit r, bit s, int ph, bit b, bit sd, int cnt);
    vec_t v;
    v.run  = r;
    v.step = s;
    v.exp  = mk(ph, b, sd, cnt);
    vecs.push_back(v);
  endtask

  task automatic check(string name, int idx, outs_t exp);
    outs_t act;
    act = {phase, imem_en, dmem_en, regfile_en, processor_en, busy, step_done, cycle_count};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %0d: got ph=%0d str=%b busy=%b done=%b cnt=%0d, want ph=%0d str=%b busy=%b done=%b cnt=%0d",
               name, idx, act.ph, act.str, act.busy, act.sd, act.cnt,
               exp.ph, exp.str, exp.busy, exp.sd, exp.cnt);
    end
  endtask

  // Entered on a falling edge; drives, waits one rising edge, compares, returns on a falling edge.
  task automatic apply_range(int lo, int hi);
    for (int i = lo; i < hi; i++) begin
      run  = vecs[i].run;
      step = vecs[i].step;
      sb.push_back(vecs[i].exp);
      @(posedge clock);
      #1;
      check("vec", i, sb.pop_front());
      @(negedge clock);
    end
  endtask

  initial begin
    // Idle after reset
    for (int i = 0; i < 20; i++) add(0, 0, 0, 0, 0, 0);
    // Free-run for three processor cycles
    for (int i = 0; i < 18; i++) add(1, 0, i % 6, 1, 0, i / 6);
    add(1, 0, 0, 1, 0, 3);
    add(1, 0, 1, 1, 0, 3);
    add(1, 0, 2, 1, 0, 3);
    // run dropped during phase 2: drain 3,4,5 then idle
    add(0, 0, 3, 1, 0, 3);
    add(0, 0, 4, 1, 0, 3);
    add(0, 0, 5, 1, 0, 3);
    add(0, 0, 0, 0, 0, 4);
    add(0, 0, 0, 0, 0, 4);
    // Single step, with a second step during the STEP cycle that must be ignored
    add(0, 1, 0, 1, 0, 4);
    add(0, 0, 1, 1, 0, 4);
    add(0, 0, 2, 1, 0, 4);
    add(0, 1, 3, 1, 0, 4);
    add(0, 0, 4, 1, 0, 4);
    add(0, 0, 5, 1, 1, 4);
    add(0, 0, 0, 0, 0, 5);
    add(0, 0, 0, 0, 0, 5);
    // run+step together (run wins), drop in phase 1, reassert in phase 3
    add(1, 1, 0, 1, 0, 5);
    add(1, 0, 1, 1, 0, 5);
    add(0, 0, 2, 1, 0, 5);
    add(0, 0, 3, 1, 0, 5);
    add(1, 0, 4, 1, 0, 5);
    add(1, 0, 5, 1, 0, 5);
    add(1, 0, 0, 1, 0, 6);
    add(1, 0, 1, 1, 0, 6);
    add(1, 0, 2, 1, 0, 6);
    add(1, 0, 3, 1, 0, 6);
    split = vecs.size();
    // Restart after the mid-cycle reset, then drain back to idle
    for (int i = 0; i < 7; i++) add(1, 0, i % 6, 1, 0, i / 6);
    for (int p = 1; p < 6; p++) add(0, 0, p, 1, 0, 1);
    add(0, 0, 0, 0, 0, 2);

    // Reset held across edges
    repeat (3) @(posedge clock);
    #1;
    check("reset_hold", 0, mk(0, 0, 0, 0));
    @(negedge clock);
    reset = 1'b1;

    apply_range(0, split);

    // Asynchronous reset in the middle of phase 3: outputs clear before the next edge
    #2 reset = 1'b0;
    #1;
    check("reset_async", 0, mk(0, 0, 0, 0));
    @(negedge clock);
    reset = 1'b1;

    apply_range(split, vecs.size());

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
